hpdcache_victim_sel: RTL and testbench
======================================

Name: hpdcache_victim_sel

Overview:
- Next-generation victim selection unit for HPDcache set-associative arrays, used on every refill allocation.
- Keeps per-set replacement state and supports three runtime-selectable policies: bit-MRU pseudo-LRU, per-set round-robin, and LFSR random.
- Supports per-request way locking and simultaneous update plus replacement.
- Returns a registered one-hot victim one cycle after each selection request.

Parameters:
- SETS, 64, number of sets (>=2).
- WAYS, 8, number of ways (>=2; need not be a power of 2).
- LFSR_SEED, 16'h0001, LFSR reset value; 0 is coerced to 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- cfg_policy_i  in  2  00 PLRU, 01 round-robin, 10 random, 11 reserved (treated as PLRU)
- clr_i  in  1  clear all PLRU bits and RR pointers
- updt_i  in  1  hit access update
- updt_set_i  in  $clog2(SETS)  set of the hit
- updt_way_i  in  WAYS  one-hot way of the hit
- repl_i  in  1  line allocated
- repl_set_i  in  $clog2(SETS)  set of the allocation
- repl_way_i  in  WAYS  one-hot allocated way
- sel_req_i  in  1  victim selection request
- sel_set_i  in  $clog2(SETS)  set to select in
- sel_dir_valid_i  in  WAYS  directory valid bits
- sel_dir_wb_i  in  WAYS  write-back line bits
- sel_dir_dirty_i  in  WAYS  dirty bits
- sel_lock_i  in  WAYS  ways excluded from selection
- sel_valid_o  out  1  victim result valid (one-cycle pulse)
- sel_victim_way_o  out  WAYS  one-hot victim
- sel_none_o  out  1  no eligible way

Behaviour:
- Reset: rst_ni, asynchronous, active-low; clock clk_i.
  - Reset clears all PLRU bits and RR pointers to 0 and loads the LFSR with LFSR_SEED.
  - Reset drives sel_valid_o=0, sel_victim_way_o=0, sel_none_o=0.
  - Reset mid-request drops the pending result.
- Eligible classes, with u = ~sel_lock_i:
  - unused = ~valid & u
  - clean = valid & ~dirty & u
  - dirty = valid & wb & dirty & u
- Class priority: unused > clean > dirty. If all three are empty: sel_none_o=1, victim=0.
- Unused class: always selects the lowest-index way.
- Clean/dirty class, according to policy:
  - PLRU: lowest-index candidate whose MRU bit is clear. If every candidate has its bit set, the lowest-index candidate (never returns 0 when candidates exist).
  - RR: first candidate at index >= ptr[set], scanning upward with wrap modulo WAYS.
  - RAND: same rotating scan, starting at lfsr mod WAYS.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle when out of reset.
- Latency:
  - sel_req_i sampled in cycle N produces sel_valid_o=1 with the victim and none flag in cycle N+1.
  - Selection uses state as of cycle N, i.e. before any updt/repl applied at the edge ending N.
  - Back-to-back requests are allowed; no backpressure.
  - Outputs hold their last value when sel_valid_o=0.
- PLRU bit update: per affected set, v = bits | way(s).
  - If v is all ones, bits become just the accessed way(s); otherwise bits = v.
- Simultaneous updt and repl:
  - Different sets: both apply.
  - Same set: the way vectors are ORed before the saturation check.
- RR pointer: on repl_i, ptr[repl_set_i] = (index(repl_way_i)+1) mod WAYS.
  - updt_i does not move the pointer.
  - A zero repl_way_i leaves the pointer and bits unchanged.
- clr_i: synchronous; effective next cycle.
  - Takes priority over updt/repl in the same cycle.
  - Does not touch the LFSR or the output registers.
- cfg_policy_i changes take effect at the next sampled request. All state is kept across policy switches, and PLRU/RR state is updated regardless of the active policy.

Decomposition:
- Package hpdcache_victim_sel_pkg:
  - policy enum (HPDCACHE_VSEL_PLRU/RR/RAND)
  - LFSR width and tap constant
  - way-index width function
- Sub-module hpdcache_rotate_prio_1hot (params N): combinational rotating-priority one-hot select given a candidate vector and a start index. Instantiated for the clean and dirty classes.
- The existing hpdcache_prio_1hot_encoder is reused for the unused class.

Test Plan (WAYS=4, SETS=4):
- Reset, valid=0000, lock=0000, req set0 -> next cycle valid=1, victim 0001, none=0.
- PLRU, valid=1111, dirty=0000:
  - updt set2 ways 0001, 0010, 0100 -> req set2 gives 1000.
  - updt 1000 -> bits=1000 -> req gives 0001.
- RR, valid=1111, clean:
  - repl set1 way 0100 -> req set1 gives 1000.
  - repl 1000 -> req gives 0001; set0 is unaffected and gives 0001.
- Lock:
  - valid=1111, lock=0011, dirty=wb=0100 -> victim 1000.
  - lock=1111 -> none=1, victim 0000.
- Simultaneous events and clear:
  - set3 bits=1100, updt 0001 plus repl 0010 same cycle -> bits 0011 -> PLRU req gives 0100.
  - clr_i together with repl -> bits 0000.
  - req in the same cycle as an updt to that set -> result reflects the old bits.
- RAND, seed 1, lock=0010: 16 consecutive reqs -> victims match the golden LFSR model; way 1 is never chosen.

Source files
------------

// File: rtl/hpdcache_victim_sel_pkg.sv
// Shared types and constants for the HPDcache victim selection unit.
package hpdcache_victim_sel_pkg;

    typedef enum logic [1:0] {
        HPDCACHE_VSEL_PLRU = 2'b00,
        HPDCACHE_VSEL_RR   = 2'b01,
        HPDCACHE_VSEL_RAND = 2'b10
    } vsel_policy_e;

    localparam int LFSR_W = 16;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic int way_idx_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Fixed-priority one-hot encoder: keeps only the lowest set bit.
module hpdcache_prio_1hot_encoder #(
    parameter int N = 4
) (
    input  logic [N-1:0] val,
    output logic [N-1:0] gnt
);
    assign gnt = val & (~val + N'(1));
endmodule

// File: rtl/hpdcache_victim_sel_rotate.sv
// Rotating-priority one-hot select: first set bit at index >= start, wrapping modulo N.
module hpdcache_rotate_prio_1hot
    import hpdcache_victim_sel_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [way_idx_w(N)-1:0]   start,
    output logic [N-1:0]              gnt
);
    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] dbl_gnt;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;

    // Rotate so that 'start' lands on bit 0, pick lowest, then rotate back
    assign dbl_req = {req, req} >> start;
    assign rot_req = dbl_req[N-1:0];
    assign rot_gnt = rot_req & (~rot_req + N'(1));
    assign dbl_gnt = {rot_gnt, rot_gnt} << start;
    assign gnt     = dbl_gnt[2*N-1:N];
endmodule

// File: rtl/hpdcache_victim_sel.sv
// Victim selection for HPDcache refills: PLRU / round-robin / random with way locking.
module hpdcache_victim_sel
    import hpdcache_victim_sel_pkg::*;
#(
    parameter int          SETS      = 64,
    parameter int          WAYS      = 8,
    parameter logic [15:0] LFSR_SEED = 16'h0001
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              cfg_policy_i,
    input  logic                    clr_i,
    input  logic                    updt_i,
    input  logic [$clog2(SETS)-1:0] updt_set_i,
    input  logic [WAYS-1:0]         updt_way_i,
    input  logic                    repl_i,
    input  logic [$clog2(SETS)-1:0] repl_set_i,
    input  logic [WAYS-1:0]         repl_way_i,
    input  logic                    sel_req_i,
    input  logic [$clog2(SETS)-1:0] sel_set_i,
    input  logic [WAYS-1:0]         sel_dir_valid_i,
    input  logic [WAYS-1:0]         sel_dir_wb_i,
    input  logic [WAYS-1:0]         sel_dir_dirty_i,
    input  logic [WAYS-1:0]         sel_lock_i,
    output logic                    sel_valid_o,
    output logic [WAYS-1:0]         sel_victim_way_o,
    output logic                    sel_none_o
);
    localparam int SET_W = $clog2(SETS);
    localparam int IDX_W = way_idx_w(WAYS);
    localparam logic [LFSR_W-1:0] SEED = (LFSR_SEED == '0) ? 16'h0001 : LFSR_SEED;

    logic [WAYS-1:0]   mru_q [SETS];
    logic [WAYS-1:0]   mru_d [SETS];
    logic [IDX_W-1:0]  ptr_q [SETS];
    logic [IDX_W-1:0]  ptr_d [SETS];
    logic [LFSR_W-1:0] lfsr_q;

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [WAYS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [WAYS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = onehot_idx(oh);
        return (idx == IDX_W'(WAYS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // Saturating bit-MRU: once every way is marked, restart from the accessed ways
    function automatic logic [WAYS-1:0] plru_next(input logic [WAYS-1:0] bits,
                                                  input logic [WAYS-1:0] acc);
        logic [WAYS-1:0] v;
        v = bits | acc;
        return (&v) ? acc : v;
    endfunction

    function automatic logic [WAYS-1:0] plru_filter(input logic [WAYS-1:0] cand,
                                                    input logic [WAYS-1:0] bits);
        logic [WAYS-1:0] f;
        f = cand & ~bits;
        return (f != '0) ? f : cand;
    endfunction

    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            logic [WAYS-1:0] acc;
            acc = '0;
            if (updt_i && (updt_set_i == SET_W'(s))) acc = acc | updt_way_i;
            if (repl_i && (repl_set_i == SET_W'(s))) acc = acc | repl_way_i;
            mru_d[s] = (acc != '0) ? plru_next(mru_q[s], acc) : mru_q[s];
            ptr_d[s] = (repl_i && (repl_set_i == SET_W'(s)) && (repl_way_i != '0))
                     ? next_ptr(repl_way_i) : ptr_q[s];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                mru_q[s] <= '0;
                ptr_q[s] <= '0;
            end
        end else if (clr_i) begin
            for (int s = 0; s < SETS; s++) begin
                mru_q[s] <= '0;
                ptr_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SETS; s++) begin
                mru_q[s] <= mru_d[s];
                ptr_q[s] <= ptr_d[s];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= SEED;
        else         lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // Selection stage: classify ways, then pick within the winning class
    logic [WAYS-1:0]  usable, cand_unused, cand_clean, cand_dirty;
    logic [WAYS-1:0]  clean_in, dirty_in, gnt_unused, gnt_clean, gnt_dirty;
    logic [WAYS-1:0]  mru_sel, victim_d;
    logic [IDX_W-1:0] start, rand_start;
    logic             none_d;

    assign usable      = ~sel_lock_i;
    assign cand_unused = ~sel_dir_valid_i & usable;
    assign cand_clean  = sel_dir_valid_i & ~sel_dir_dirty_i & usable;
    assign cand_dirty  = sel_dir_valid_i & sel_dir_wb_i & sel_dir_dirty_i & usable;
    assign mru_sel     = mru_q[sel_set_i];
    assign rand_start  = IDX_W'(lfsr_q % LFSR_W'(WAYS));

    always_comb begin
        start    = '0;
        clean_in = plru_filter(cand_clean, mru_sel);
        dirty_in = plru_filter(cand_dirty, mru_sel);
        case (cfg_policy_i)
            HPDCACHE_VSEL_RR: begin
                start    = ptr_q[sel_set_i];
                clean_in = cand_clean;
                dirty_in = cand_dirty;
            end
            HPDCACHE_VSEL_RAND: begin
                start    = rand_start;
                clean_in = cand_clean;
                dirty_in = cand_dirty;
            end
            default: ;
        endcase
    end

    hpdcache_prio_1hot_encoder #(.N(WAYS)) u_unused_enc (
        .val (cand_unused),
        .gnt (gnt_unused)
    );

    hpdcache_rotate_prio_1hot #(.N(WAYS)) u_clean_sel (
        .req   (clean_in),
        .start (start),
        .gnt   (gnt_clean)
    );

    hpdcache_rotate_prio_1hot #(.N(WAYS)) u_dirty_sel (
        .req   (dirty_in),
        .start (start),
        .gnt   (gnt_dirty)
    );

    always_comb begin
        victim_d = '0;
        if      (cand_unused != '0) victim_d = gnt_unused;
        else if (cand_clean  != '0) victim_d = gnt_clean;
        else if (cand_dirty  != '0) victim_d = gnt_dirty;
    end

    assign none_d = ((cand_unused | cand_clean | cand_dirty) == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_valid_o      <= 1'b0;
            sel_victim_way_o <= '0;
            sel_none_o       <= 1'b0;
        end else begin
            sel_valid_o <= sel_req_i;
            if (sel_req_i) begin
                sel_victim_way_o <= victim_d;
                sel_none_o       <= none_d;
            end
        end
    end

endmodule

// File: tb/tb_hpdcache_victim_sel.sv
// Directed table-driven bench for hpdcache_victim_sel with WAYS=4, SETS=4.
module tb_hpdcache_victim_sel;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] cfg_policy;
    logic       clr, updt, repl, sel_req;
    logic [1:0] updt_set, repl_set, sel_set;
    logic [3:0] updt_way, repl_way;
    logic [3:0] sel_dir_valid, sel_dir_wb, sel_dir_dirty, sel_lock;
    logic       sel_valid, sel_none;
    logic [3:0] sel_victim_way;

    int checks = 0;
    int errors = 0;
    logic [3:0]  last_vic = 4'b0000;
    logic [15:0] lfsr_m;

    always #5 clk = ~clk;

    hpdcache_victim_sel #(.SETS(4), .WAYS(4), .LFSR_SEED(16'h0001)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .cfg_policy_i     (cfg_policy),
        .clr_i            (clr),
        .updt_i           (updt),
        .updt_set_i       (updt_set),
        .updt_way_i       (updt_way),
        .repl_i           (repl),
        .repl_set_i       (repl_set),
        .repl_way_i       (repl_way),
        .sel_req_i        (sel_req),
        .sel_set_i        (sel_set),
        .sel_dir_valid_i  (sel_dir_valid),
        .sel_dir_wb_i     (sel_dir_wb),
        .sel_dir_dirty_i  (sel_dir_dirty),
        .sel_lock_i       (sel_lock),
        .sel_valid_o      (sel_valid),
        .sel_victim_way_o (sel_victim_way),
        .sel_none_o       (sel_none)
    );

    // Golden LFSR: 16-bit Fibonacci, taps 16,14,13,11
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) lfsr_m <= 16'h0001;
        else         lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    typedef struct {
        logic [1:0] pol;
        logic       clr;
        logic       updt;
        logic [1:0] uset;
        logic [3:0] uway;
        logic       repl;
        logic [1:0] rset;
        logic [3:0] rway;
        logic       req;
        logic [1:0] set;
        logic [3:0] vld, wb, dty, lck;
        logic [3:0] exp_vic;
        logic       exp_none;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] pol, input logic c,
                                input logic u, input logic [1:0] us, input logic [3:0] uw,
                                input logic r, input logic [1:0] rs, input logic [3:0] rw,
                                input logic q, input logic [1:0] s,
                                input logic [3:0] vld, input logic [3:0] wb,
                                input logic [3:0] dty, input logic [3:0] lck,
                                input logic [3:0] ev, input logic en);
        vec_t v;
        v.pol = pol; v.clr = c; v.updt = u; v.uset = us; v.uway = uw;
        v.repl = r; v.rset = rs; v.rway = rw; v.req = q; v.set = s;
        v.vld = vld; v.wb = wb; v.dty = dty; v.lck = lck;
        v.exp_vic = ev; v.exp_none = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        cfg_policy = 2'b00; clr = 1'b0; updt = 1'b0; repl = 1'b0; sel_req = 1'b0;
        updt_set = 2'd0; repl_set = 2'd0; sel_set = 2'd0;
        updt_way = 4'b0; repl_way = 4'b0;
        sel_dir_valid = 4'b0; sel_dir_wb = 4'b0; sel_dir_dirty = 4'b0; sel_lock = 4'b0;
    endtask

    task automatic apply(input vec_t v, input int n);
        cfg_policy = v.pol; clr = v.clr;
        updt = v.updt; updt_set = v.uset; updt_way = v.uway;
        repl = v.repl; repl_set = v.rset; repl_way = v.rway;
        sel_req = v.req; sel_set = v.set;
        sel_dir_valid = v.vld; sel_dir_wb = v.wb; sel_dir_dirty = v.dty; sel_lock = v.lck;
        @(posedge clk); #1;
        if (v.req) begin
            chk($sformatf("row%0d_valid", n), 32'(sel_valid), 32'd1);
            chk($sformatf("row%0d_victim", n), 32'(sel_victim_way), 32'(v.exp_vic));
            chk($sformatf("row%0d_none", n), 32'(sel_none), 32'(v.exp_none));
            last_vic = v.exp_vic;
        end else begin
            chk($sformatf("row%0d_idle_valid", n), 32'(sel_valid), 32'd0);
            chk($sformatf("row%0d_hold_victim", n), 32'(sel_victim_way), 32'(last_vic));
        end
    endtask

    function automatic logic [3:0] rand_exp(input logic [15:0] l, input logic [3:0] cand);
        int st;
        st = int'(l % 16'd4);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (st + i) % 4;
            if (cand[k]) return 4'b0001 << k;
        end
        return 4'b0000;
    endfunction

    initial begin
        logic [3:0] exp_r;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(sel_valid), 32'd0);
        chk("reset_victim", 32'(sel_victim_way), 32'd0);
        chk("reset_none", 32'(sel_none), 32'd0);
        rst_ni = 1'b1;

        //         pol  clr  updt set way      repl set way      req set vld      wb       dty      lck      exp      none
        vecs.push_back(mk(2'd0, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0));
        vecs.push_back(mk(2'd0, 0, 1, 2'd2, 4'b0001, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd0, 0, 1, 2'd2, 4'b0010, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd0, 0, 1, 2'd2, 4'b0100, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd0, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd2, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0));
        vecs.push_back(mk(2'd0, 0, 1, 2'd2, 4'b1000, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd0, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd2, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 1, 2'd1, 4'b0100, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 1, 2'd1, 4'b1000, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd0, 4'b1111, 4'b0100, 4'b0100, 4'b0011, 4'b1000, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd0, 4'b1111, 4'b0100, 4'b0100, 4'b1111, 4'b0000, 1));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0));
        vecs.push_back(mk(2'd0, 0, 1, 2'd3, 4'b1000, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd0, 0, 1, 2'd3, 4'b0100, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd0, 0, 1, 2'd3, 4'b0001, 1, 2'd3, 4'b0010, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd0, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd3, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0));
        vecs.push_back(mk(2'd0, 1, 0, 2'd0, 4'b0000, 1, 2'd3, 4'b0100, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd0, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd3, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd3, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0));
        vecs.push_back(mk(2'd0, 0, 1, 2'd0, 4'b0001, 0, 2'd0, 4'b0000, 1, 2'd0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0));
        vecs.push_back(mk(2'd0, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0));
        vecs.push_back(mk(2'd0, 0, 1, 2'd1, 4'b0001, 1, 2'd2, 4'b0001, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd0, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0));
        vecs.push_back(mk(2'd0, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd2, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd2, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 1, 2'd1, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(2'd1, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0));
        vecs.push_back(mk(2'd3, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1, 2'd1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset asserted while a request is in flight drops the result
        idle();
        cfg_policy = 2'd0; sel_req = 1'b1; sel_set = 2'd1; sel_dir_valid = 4'b1111;
        #3 rst_ni = 1'b0;
        @(posedge clk); #1;
        chk("midreset_valid", 32'(sel_valid), 32'd0);
        chk("midreset_victim", 32'(sel_victim_way), 32'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        chk("postreset_plru_victim", 32'(sel_victim_way), 32'b0001);
        chk("postreset_plru_valid", 32'(sel_valid), 32'd1);

        // Random policy against the golden LFSR, way 1 locked
        idle();
        cfg_policy = 2'd2; sel_req = 1'b1; sel_set = 2'd0;
        sel_dir_valid = 4'b1111; sel_lock = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            exp_r = rand_exp(lfsr_m, 4'b1101);
            @(posedge clk); #1;
            chk($sformatf("rand%0d_victim", i), 32'(sel_victim_way), 32'(exp_r));
            chk($sformatf("rand%0d_way1_free", i), 32'(sel_victim_way[1]), 32'd0);
        end
        idle();
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
